// File: rtl/rf_arbiter_pkg.sv
// Shared types and default geometry for the register-file port arbiter.
package rf_arbiter_pkg;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned RF_DEPTH   = 2 ** DEF_ADDR_W;

   typedef enum logic {
      CLEAR,
      SERVE
   } rfa_state_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer lives here.
module rf_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 means requester 1 was granted most recently, so requester 0 wins the first tie
   logic last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last <= grant[1];
      end
   end

   always_comb begin
      grant = '0;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/rf_arbiter.sv
// Register-file port owner: zero sweep after reset, then round-robin service
// of two requesters at one transaction per cycle.
module rf_arbiter
   import rf_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned CLEAR_ON_RESET = 1
) (
   input  logic              RFA_clk,
   input  logic              RFA_Reset_n,
   input  logic              RFA_Req_0,
   input  logic              RFA_Req_1,
   input  logic              RFA_Write_0,
   input  logic              RFA_Write_1,
   input  logic [ADDR_W-1:0] RFA_Addr_0,
   input  logic [ADDR_W-1:0] RFA_Addr_1,
   input  logic [DATA_W-1:0] RFA_WData_0,
   input  logic [DATA_W-1:0] RFA_WData_1,
   output logic              RFA_Ack_0,
   output logic              RFA_Ack_1,
   output logic              RFA_RValid_0,
   output logic              RFA_RValid_1,
   output logic [DATA_W-1:0] RFA_RData,
   output logic              RFA_Busy,
   output logic              RF_We,
   output logic [ADDR_W-1:0] RF_WAddr,
   output logic [DATA_W-1:0] RF_WData,
   output logic [ADDR_W-1:0] RF_RAddr,
   input  logic [DATA_W-1:0] RF_RData
);

   localparam rfa_state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : SERVE;

   rfa_state_t        state_q, state_d;
   logic [ADDR_W-1:0] sweep_q;
   logic              in_clear, in_serve;
   logic [1:0]        grant;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        read_grant;
   logic [1:0]        rvalid_q;
   logic [DATA_W-1:0] rdata_q;

   // Reset level gates the port drivers so nothing reaches the file while reset is held
   assign in_clear = RFA_Reset_n && (state_q == CLEAR);
   assign in_serve = RFA_Reset_n && (state_q == SERVE);

   always_ff @(posedge RFA_clk or negedge RFA_Reset_n) begin
      if (!RFA_Reset_n) begin
         state_q <= RESET_STATE;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            sweep_q <= sweep_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      if ((state_q == CLEAR) && (sweep_q == '1)) begin
         state_d = SERVE;
      end
   end

   rf_rr_arb2 u_arb (
      .clk     (RFA_clk),
      .rst_n   (RFA_Reset_n),
      .req     ({RFA_Req_1, RFA_Req_0} & {2{in_serve}}),
      .advance (in_serve),
      .grant   (grant)
   );

   always_comb begin
      sel_write = grant[1] ? RFA_Write_1 : RFA_Write_0;
      sel_addr  = grant[1] ? RFA_Addr_1  : RFA_Addr_0;
      sel_wdata = grant[1] ? RFA_WData_1 : RFA_WData_0;
   end

   assign read_grant = grant & {2{~sel_write}};

   always_comb begin
      RF_We    = 1'b0;
      RF_WAddr = '0;
      RF_WData = '0;
      RF_RAddr = '0;
      if (in_clear) begin
         RF_We    = 1'b1;
         RF_WAddr = sweep_q;
      end else if (grant != 2'b00) begin
         if (sel_write) begin
            RF_We    = 1'b1;
            RF_WAddr = sel_addr;
            RF_WData = sel_wdata;
         end else begin
            RF_RAddr = sel_addr;
         end
      end
   end

   always_ff @(posedge RFA_clk or negedge RFA_Reset_n) begin
      if (!RFA_Reset_n) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= read_grant;
         if (read_grant != 2'b00) begin
            rdata_q <= RF_RData;
         end
      end
   end

   assign RFA_Ack_0    = grant[0];
   assign RFA_Ack_1    = grant[1];
   assign RFA_RValid_0 = rvalid_q[0];
   assign RFA_RValid_1 = rvalid_q[1];
   assign RFA_RData    = rdata_q;
   assign RFA_Busy     = (state_q == CLEAR);

endmodule
